// File: rtl/axi4_stream_downsizer_if.sv
`default_nettype none
// ============================================================================
// Module      : axi4_stream_if
// Description : AXI4-Stream bundle with master/slave views, parameterised in
//               data and sideband widths.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
) ();

  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (
    output tdata, tstrb, tkeep, tid, tdest, tuser, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tstrb, tkeep, tid, tdest, tuser, tvalid, tlast,
    output tready
  );

endinterface
`default_nettype wire

// File: rtl/axi4_stream_downsizer.sv
`default_nettype none
// ============================================================================
// Module      : axi4_stream_downsizer
// Description : Splits each wide AXI4-Stream beat into RATIO narrow beats,
//               least-significant chunk first. On the tlast beat, trailing
//               chunks with no tkeep bits set are not emitted.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_stream_downsizer #(
  parameter int RX_TDATA_WIDTH = 64,
  parameter int TX_TDATA_WIDTH = 16,
  parameter int TID_WIDTH      = 1,
  parameter int TDEST_WIDTH    = 1,
  parameter int TUSER_WIDTH    = 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  axi4_stream_if.slave  pkt_i,
  axi4_stream_if.master pkt_o
);

  localparam int C_RATIO = RX_TDATA_WIDTH / TX_TDATA_WIDTH;
  localparam int C_RX_B  = RX_TDATA_WIDTH / 8;
  localparam int C_TX_B  = TX_TDATA_WIDTH / 8;
  localparam int C_IDX_W = $clog2(C_RATIO);
  localparam logic [C_IDX_W-1:0] C_LAST_CHUNK = C_IDX_W'(C_RATIO - 1);

  // Holding register for one wide beat
  logic [RX_TDATA_WIDTH-1:0] r_data;
  logic [C_RX_B-1:0]         r_keep;
  logic [C_RX_B-1:0]         r_strb;
  logic [TID_WIDTH-1:0]      r_id;
  logic [TDEST_WIDTH-1:0]    r_dest;
  logic [TUSER_WIDTH-1:0]    r_user;
  logic                      r_last;
  logic                      r_buf_valid;
  logic [C_IDX_W-1:0]        r_idx;
  logic [C_IDX_W-1:0]        r_last_idx;

  logic [TX_TDATA_WIDTH-1:0] w_chunk_data [C_RATIO];
  logic [C_TX_B-1:0]         w_chunk_keep [C_RATIO];
  logic [C_TX_B-1:0]         w_chunk_strb [C_RATIO];
  logic [C_RATIO-1:0]        w_rx_chunk_kept;
  logic [C_IDX_W-1:0]        w_rx_hi_idx;
  logic                      w_at_end;
  logic                      w_rx_ready;
  logic                      w_rx_hs;
  logic                      w_tx_hs;

  // Slice the held beat into narrow chunks, and flag which incoming chunks
  // carry at least one kept byte.
  generate
    for (genvar g = 0; g < C_RATIO; g++) begin : g_chunk
      assign w_chunk_data[g]    = r_data[g*TX_TDATA_WIDTH +: TX_TDATA_WIDTH];
      assign w_chunk_keep[g]    = r_keep[g*C_TX_B +: C_TX_B];
      assign w_chunk_strb[g]    = r_strb[g*C_TX_B +: C_TX_B];
      assign w_rx_chunk_kept[g] = |pkt_i.tkeep[g*C_TX_B +: C_TX_B];
    end
  endgenerate

  // Highest incoming chunk with any kept byte (0 when tkeep is all zero)
  always_comb begin
    w_rx_hi_idx = '0;
    for (int i = 0; i < C_RATIO; i++) begin
      if (w_rx_chunk_kept[i]) begin
        w_rx_hi_idx = C_IDX_W'(i);
      end
    end
  end

  // A new wide beat can enter when the buffer is empty or its final chunk
  // leaves this cycle; tready is held low while reset is asserted.
  assign w_at_end   = (r_idx == r_last_idx);
  assign w_rx_ready = rst_n_i & (~r_buf_valid | (pkt_o.tready & w_at_end));
  assign w_rx_hs    = pkt_i.tvalid & w_rx_ready;
  assign w_tx_hs    = r_buf_valid & pkt_o.tready;

  assign pkt_i.tready = w_rx_ready;

  // Narrow output driven purely from registers
  assign pkt_o.tvalid = r_buf_valid;
  assign pkt_o.tdata  = w_chunk_data[r_idx];
  assign pkt_o.tkeep  = w_chunk_keep[r_idx];
  assign pkt_o.tstrb  = w_chunk_strb[r_idx];
  assign pkt_o.tid    = r_id;
  assign pkt_o.tdest  = r_dest;
  assign pkt_o.tuser  = r_user;
  assign pkt_o.tlast  = r_last & w_at_end;

  // Chunk sequencing and wide-beat capture; a load in the same cycle as the
  // final chunk leaving overrides the end-of-beat clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_data      <= '0;
      r_keep      <= '0;
      r_strb      <= '0;
      r_id        <= '0;
      r_dest      <= '0;
      r_user      <= '0;
      r_last      <= 1'b0;
      r_buf_valid <= 1'b0;
      r_idx       <= '0;
      r_last_idx  <= '0;
    end else begin
      if (w_tx_hs) begin
        if (!w_at_end) begin
          r_idx <= r_idx + 1'b1;
        end else begin
          r_buf_valid <= 1'b0;
          r_idx       <= '0;
        end
      end
      if (w_rx_hs) begin
        r_data      <= pkt_i.tdata;
        r_keep      <= pkt_i.tkeep;
        r_strb      <= pkt_i.tstrb;
        r_id        <= pkt_i.tid;
        r_dest      <= pkt_i.tdest;
        r_user      <= pkt_i.tuser;
        r_last      <= pkt_i.tlast;
        r_buf_valid <= 1'b1;
        r_idx       <= '0;
        r_last_idx  <= pkt_i.tlast ? w_rx_hi_idx : C_LAST_CHUNK;
      end
    end
  end

endmodule
`default_nettype wire
